xup_rr_reg_arbiter: RTL and testbench
=====================================

Name: xup_rr_reg_arbiter

Overview:
Round-robin arbiter and load sequencer that shares one SIZE-bit clocked data register among NREQ requesters. Each requester asks for the register with a level request. The block grants one requester at a time, loads that requester's data word, acknowledges it, and then holds the value for a programmable settle period. It sits between several producer blocks and one shared downstream register, such as a display or output latch on the board.

Parameters:
NREQ, 4, number of requesters (2..8)
SIZE, 4, data width of each requester word and of the shared register
HOLD, 3, cycles the loaded value is held before the next arbitration (0..15)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous, active-low reset
req  input  NREQ  level request, one bit per requester; held until ack
din  input  NREQ*SIZE  packed data words; requester i uses din[i*SIZE +: SIZE]
gnt  output  NREQ  one-hot grant, registered
ack  output  NREQ  one-cycle pulse: requester's word has been loaded
q  output  SIZE  shared register contents
q_src  output  3  index of the requester that last loaded q
q_valid  output  1  high once q holds a loaded word

Behaviour:
- Reset (rst_n low, asynchronous) forces the following values; they hold until the first clock edge after rst_n rises:
  - state=IDLE, gnt=0, ack=0, q=0, q_src=0, q_valid=0.
  - Round-robin pointer ptr=NREQ-1, so requester 0 wins first.
- Reset asserted mid-operation aborts any grant or hold immediately, with no ack.
- Registered FSM with states IDLE, GRANT, HOLD.
- IDLE:
  - If req!=0, select the first set bit searching ptr+1, ptr+2, ... modulo NREQ.
  - Next edge: gnt=onehot(sel), state=GRANT.
  - If req==0, stay in IDLE with gnt=0.
- GRANT, with granted index g:
  - If req[g]=1 at the edge: q<=din slice g, q_src<=g, q_valid<=1, ack[g]<=1 for one cycle, ptr<=g, gnt<=0.
    - Next state is HOLD if HOLD>0, else IDLE.
  - If req[g]=0 at the edge (withdrawn): abort. No load, no ack, ptr unchanged, gnt<=0, state=IDLE.
- HOLD:
  - A counter loads HOLD-1 on entry and decrements each cycle; gnt=0.
  - When the count reaches 0, go to IDLE.
  - Requests arriving during HOLD are queued as levels and are not granted until IDLE.
- Latency:
  - req rising in IDLE at edge k gives gnt at edge k+1.
  - q and ack update at edge k+2.
  - The earliest next gnt is at edge k+3+HOLD.
- Fairness:
  - The pointer advances only on a successful load.
  - With all requesters continuously requesting, grants rotate 0,1,...,NREQ-1,0.
  - Any single requester waits at most NREQ-1 other loads.
- Simultaneous events:
  - Several req bits rising in the same cycle: the lowest index after ptr wins.
  - A requester dropping req in the same cycle its ack pulses is legal.
  - A requester that keeps req high after ack is treated as a new request.
- Exactly one gnt bit is high at most; gnt and ack are never high in the same cycle.
- q, q_src and q_valid change only on successful loads; they are unchanged by aborts.
- Width rules:
  - q_src is always 3 bits; unused upper bits are 0.
  - The HOLD counter is 4 bits; HOLD=0 skips the HOLD state entirely.

Decomposition:
- Shared package xup_arb_pkg holds:
  - The state encoding constants IDLE=2'd0, GRANT=2'd1, HOLD=2'd2.
  - The function rr_pick(req, ptr), returning a 3-bit index plus a found flag.
- Sub-module xup_rr_pick: purely combinational priority rotate. It takes req and ptr and produces sel and any.
- The top level holds the FSM, HOLD counter, pointer and output registers.
- The data register may be built by instantiating xup_dff_vector with SIZE, with its load gated through a mux.

Test Plan:
- Reset mid-HOLD: load req=0001, din0=4'hA, pull rst_n low mid-HOLD -> q=0, q_valid=0 and gnt=0 immediately; after release with req=0, everything stays idle.
- Single request: req=0100, din2=4'h5 at edge 0 -> gnt=0100 at edge 1; q=5, q_src=2, ack=0100 at edge 2; gnt=0 through edge 2+HOLD=5.
- All requesting: req=1111, din words 1,2,3,4 -> loads in order q=1,2,3,4,1 with q_src=0,1,2,3,0, spaced HOLD+2=5 cycles apart.
- Withdrawal: req=0010 granted, then req dropped in the GRANT cycle -> no ack, q unchanged, ptr unchanged; a following req=0011 grants requester 0 first.
- HOLD=0 build, req=1001 held -> alternating grants 0,3,0,3 every 2 cycles; no cycle has gnt and ack both high.

Source files
------------

// File: rtl/xup_arb_pkg.sv
// Shared definitions for the round-robin register arbiter:
// state encoding and the rotating priority search.
package xup_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam int MAX_REQ = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // Search ptr+1, ptr+2, ... wrapping at nreq; the first set request wins.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                    input logic [2:0]         ptr,
                                    input int unsigned        nreq);
    pick_t      r;
    logic [3:0] s;
    r = '0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      s = {1'b0, ptr} + 4'(k);
      if (s >= 4'(nreq)) s = s - 4'(nreq);
      if ((k <= int'(nreq)) && !r.found && req[s[2:0]]) begin
        r.found = 1'b1;
        r.idx   = s[2:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/xup_rr_pick.sv
// Combinational round-robin selector: next requester after ptr.
module xup_rr_pick
  import xup_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      ptr,
  output logic [2:0]      sel,
  output logic            any
);

  pick_t pick;

  always_comb begin
    pick = rr_pick(MAX_REQ'(req), ptr, NREQ);
    sel  = pick.idx;
    any  = pick.found;
  end

endmodule

// File: rtl/xup_rr_reg_arbiter.sv
// Round-robin arbiter that loads one requester's word into a shared register,
// acknowledges it, then holds the value for HOLD cycles before rearbitrating.
module xup_rr_reg_arbiter
  import xup_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int SIZE = 4,
  parameter int HOLD = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*SIZE-1:0] din,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      ack,
  output logic [SIZE-1:0]      q,
  output logic [2:0]           q_src,
  output logic                 q_valid
);

  localparam logic [3:0] HOLD_INIT = 4'((HOLD > 0) ? HOLD - 1 : 0);
  localparam logic [2:0] PTR_INIT  = 3'(NREQ - 1);

  state_t          state;
  logic [2:0]      ptr;
  logic [2:0]      g;
  logic [3:0]      cnt;
  logic [2:0]      sel;
  logic            any;
  logic [NREQ-1:0] sel_oh;
  logic [NREQ-1:0] g_oh;
  logic [SIZE-1:0] g_word;
  logic            g_req;

  xup_rr_pick #(.NREQ(NREQ)) u_pick (
    .req (req),
    .ptr (ptr),
    .sel (sel),
    .any (any)
  );

  always_comb begin
    sel_oh = '0;
    g_oh   = '0;
    g_word = '0;
    g_req  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      sel_oh[i] = (sel == 3'(i));
      if (g == 3'(i)) begin
        g_oh[i] = 1'b1;
        g_word  = din[i*SIZE +: SIZE];
        g_req   = req[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      gnt     <= '0;
      ack     <= '0;
      q       <= '0;
      q_src   <= '0;
      q_valid <= 1'b0;
      ptr     <= PTR_INIT;
      g       <= '0;
      cnt     <= '0;
    end else begin
      ack <= '0;
      case (state)
        ST_IDLE: begin
          if (any) begin
            gnt   <= sel_oh;
            g     <= sel;
            state <= ST_GRANT;
          end else begin
            gnt <= '0;
          end
        end
        ST_GRANT: begin
          gnt <= '0;
          // A withdrawn request aborts without touching q or the pointer.
          if (g_req) begin
            q       <= g_word;
            q_src   <= g;
            q_valid <= 1'b1;
            ack     <= g_oh;
            ptr     <= g;
            if (HOLD > 0) begin
              state <= ST_HOLD;
              cnt   <= HOLD_INIT;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          gnt <= '0;
          if (cnt == 4'd0) state <= ST_IDLE;
          else             cnt   <= cnt - 4'd1;
        end
        default: begin
          gnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xup_rr_reg_arbiter.sv
// Bench for xup_rr_reg_arbiter: vector table for the single-request and
// withdrawal paths, hand sequences for reset, and a load scoreboard.
module tb_xup_rr_reg_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req, req_b;
  logic [15:0] din, din_b;
  logic [3:0]  gnt, ack, q;
  logic [3:0]  gnt_b, ack_b, q_b;
  logic [2:0]  q_src, q_src_b;
  logic        q_valid, q_valid_b;

  always #5 clk = ~clk;

  xup_rr_reg_arbiter #(.NREQ(4), .SIZE(4), .HOLD(3)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din),
    .gnt(gnt), .ack(ack), .q(q), .q_src(q_src), .q_valid(q_valid)
  );

  xup_rr_reg_arbiter #(.NREQ(4), .SIZE(4), .HOLD(0)) dut_h0 (
    .clk(clk), .rst_n(rst_n), .req(req_b), .din(din_b),
    .gnt(gnt_b), .ack(ack_b), .q(q_b), .q_src(q_src_b), .q_valid(q_valid_b)
  );

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [3:0] ack;
    logic [3:0] q;
    logic [2:0] src;
    logic       valid;
  } vec_t;

  typedef struct packed {
    logic [3:0] q;
    logic [2:0] src;
  } exp_t;

  vec_t tbl[17];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [3:0] eg, input logic [3:0] ea,
                           input logic [3:0] eq, input logic [2:0] es, input logic ev);
    check({tag, "_gnt"}, gnt, eg);
    check({tag, "_ack"}, ack, ea);
    check({tag, "_q"}, q, eq);
    check({tag, "_src"}, q_src, es);
    check({tag, "_valid"}, q_valid, ev);
  endtask

  task automatic run_sb(input bit use_b, input int spacing, input int budget);
    logic [3:0] cg, ca, cq;
    logic [2:0] cs;
    exp_t       e;
    int         last;
    last = -1;
    for (int c = 0; c < budget && sb.size() > 0; c++) begin
      step();
      cg = use_b ? gnt_b   : gnt;
      ca = use_b ? ack_b   : ack;
      cq = use_b ? q_b     : q;
      cs = use_b ? q_src_b : q_src;
      check("gnt_ack_overlap", cg & ca, 0);
      check("gnt_onehot0", 32'($onehot0(cg)), 1);
      if (ca != 4'b0000) begin
        e = sb.pop_front();
        check("load_q", cq, e.q);
        check("load_src", cs, e.src);
        check("load_ack", ca, 4'b0001 << e.src);
        if (last >= 0) check("load_spacing", c - last, spacing);
        last = c;
      end
    end
    check("sb_drain", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // din words: din3=0, din2=5, din1=7, din0=3
    tbl[0]  = '{4'b0100, 4'b0100, 4'b0000, 4'h0, 3'd0, 1'b0};
    tbl[1]  = '{4'b0100, 4'b0000, 4'b0100, 4'h5, 3'd2, 1'b1};
    tbl[2]  = '{4'b0100, 4'b0000, 4'b0000, 4'h5, 3'd2, 1'b1};
    tbl[3]  = '{4'b0100, 4'b0000, 4'b0000, 4'h5, 3'd2, 1'b1};
    tbl[4]  = '{4'b0100, 4'b0000, 4'b0000, 4'h5, 3'd2, 1'b1};
    tbl[5]  = '{4'b0100, 4'b0100, 4'b0000, 4'h5, 3'd2, 1'b1};
    tbl[6]  = '{4'b0000, 4'b0000, 4'b0000, 4'h5, 3'd2, 1'b1};
    tbl[7]  = '{4'b0010, 4'b0010, 4'b0000, 4'h5, 3'd2, 1'b1};
    tbl[8]  = '{4'b0000, 4'b0000, 4'b0000, 4'h5, 3'd2, 1'b1};
    tbl[9]  = '{4'b0011, 4'b0001, 4'b0000, 4'h5, 3'd2, 1'b1};
    tbl[10] = '{4'b0011, 4'b0000, 4'b0001, 4'h3, 3'd0, 1'b1};
    tbl[11] = '{4'b0010, 4'b0000, 4'b0000, 4'h3, 3'd0, 1'b1};
    tbl[12] = '{4'b0010, 4'b0000, 4'b0000, 4'h3, 3'd0, 1'b1};
    tbl[13] = '{4'b0010, 4'b0000, 4'b0000, 4'h3, 3'd0, 1'b1};
    tbl[14] = '{4'b0010, 4'b0010, 4'b0000, 4'h3, 3'd0, 1'b1};
    tbl[15] = '{4'b0010, 4'b0000, 4'b0010, 4'h7, 3'd1, 1'b1};
    tbl[16] = '{4'b0000, 4'b0000, 4'b0000, 4'h7, 3'd1, 1'b1};

    rst_n = 1'b0;
    req   = '0;
    req_b = '0;
    din   = 16'h0573;
    din_b = 16'h9006;
    #1;
    check_all("reset", 4'b0, 4'b0, 4'h0, 3'd0, 1'b0);
    check("reset_gnt_h0", gnt_b, 0);
    step();
    check_all("reset_clk", 4'b0, 4'b0, 4'h0, 3'd0, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      req = tbl[i].req;
      step();
      check_all($sformatf("row%0d", i), tbl[i].gnt, tbl[i].ack, tbl[i].q, tbl[i].src, tbl[i].valid);
    end

    // Reset during HOLD
    req = '0;
    repeat (3) step();
    din = 16'h057A;
    req = 4'b0001;
    step();
    check("rh_gnt", gnt, 4'b0001);
    step();
    check("rh_load_q", q, 4'hA);
    check("rh_load_ack", ack, 4'b0001);
    req = '0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check_all("rh_async", 4'b0, 4'b0, 4'h0, 3'd0, 1'b0);
    step();
    step();
    check_all("rh_held", 4'b0, 4'b0, 4'h0, 3'd0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_all($sformatf("rh_idle%0d", i), 4'b0, 4'b0, 4'h0, 3'd0, 1'b0);
    end

    // All requesting, fresh pointer: rotation starts at requester 0
    din = 16'h4321;
    req = 4'b1111;
    sb.push_back('{4'h1, 3'd0});
    sb.push_back('{4'h2, 3'd1});
    sb.push_back('{4'h3, 3'd2});
    sb.push_back('{4'h4, 3'd3});
    sb.push_back('{4'h1, 3'd0});
    run_sb(1'b0, 5, 60);
    req = '0;

    // HOLD=0 instance: requesters 0 and 3 alternate every two cycles
    req_b = 4'b1001;
    sb.push_back('{4'h6, 3'd0});
    sb.push_back('{4'h9, 3'd3});
    sb.push_back('{4'h6, 3'd0});
    sb.push_back('{4'h9, 3'd3});
    run_sb(1'b1, 2, 30);
    req_b = '0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
